multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencing,
// datapath strobe decode, and memory-ready timeout trapping.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        IMemReady,
  input  logic        DMemReady,
  output logic        IMemReq,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        DMemRead,
  output logic        DMemWrite,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        ALUASrc,
  output logic        ExtendSign,
  output logic [1:0]  PCSrc,
  output logic [1:0]  RegDst,
  output logic [1:0]  RegDataSel,
  output logic [3:0]  ALUControl,
  output logic [2:0]  ALUBSrc,
  output logic [2:0]  State,
  output logic        Illegal,
  output logic        Fault
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [5:0] OP_R     = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] F_SLL  = 6'd0;
  localparam logic [5:0] F_JR   = 6'd8;
  localparam logic [5:0] F_ADD  = 6'd32;
  localparam logic [5:0] F_ADDU = 6'd33;
  localparam logic [5:0] F_SUB  = 6'd34;
  localparam logic [5:0] F_AND  = 6'd36;
  localparam logic [5:0] F_OR   = 6'd37;
  localparam logic [5:0] F_XOR  = 6'd38;
  localparam logic [5:0] F_NOR  = 6'd39;
  localparam logic [5:0] F_SLT  = 6'd42;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JR, C_JAL
  } cls_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             fault_q;

  cls_t       cls;
  logic       legal;
  logic       r_type;
  logic [3:0] alu_ctl;
  logic [2:0] alu_b;
  logic       alu_a;
  logic       ext_sign;
  logic       cnt_hit;
  logic       waiting;

  // Instruction decode; meaningful whenever Instr holds the current IR.
  always_comb begin
    cls      = C_ALU;
    legal    = 1'b1;
    r_type   = 1'b0;
    alu_ctl  = 4'd0;
    alu_b    = 3'd0;
    alu_a    = 1'b0;
    ext_sign = 1'b0;
    case (Instr[31:26])
      OP_R: begin
        r_type = 1'b1;
        case (Instr[5:0])
          F_ADD, F_ADDU: alu_ctl = 4'd2;
          F_SUB:         alu_ctl = 4'd6;
          F_AND:         alu_ctl = 4'd0;
          F_OR:          alu_ctl = 4'd1;
          F_XOR:         alu_ctl = 4'd4;
          F_NOR:         alu_ctl = 4'd3;
          F_SLT:         alu_ctl = 4'd7;
          F_SLL: begin
            alu_ctl = 4'd10;
            alu_b   = 3'd4;
            alu_a   = 1'b1;
          end
          F_JR:          cls = C_JR;
          default:       legal = 1'b0;
        endcase
      end
      OP_ADDI: begin
        alu_ctl  = 4'd2;
        alu_b    = 3'd1;
        ext_sign = 1'b1;
      end
      OP_ADDIU: begin
        alu_ctl = 4'd2;
        alu_b   = 3'd1;
      end
      OP_ANDI: begin
        alu_ctl = 4'd0;
        alu_b   = 3'd1;
      end
      OP_ORI: begin
        alu_ctl = 4'd1;
        alu_b   = 3'd1;
      end
      OP_LW, OP_SW: begin
        cls      = (Instr[31:26] == OP_LW) ? C_LW : C_SW;
        alu_ctl  = 4'd2;
        alu_b    = 3'd1;
        ext_sign = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        cls      = (Instr[31:26] == OP_BEQ) ? C_BEQ : C_BNE;
        alu_ctl  = 4'd6;
        ext_sign = 1'b1;
      end
      OP_J:    cls = C_J;
      OP_JAL:  cls = C_JAL;
      default: legal = 1'b0;
    endcase
  end

  assign cnt_hit = (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
  assign waiting = ((state == FETCH) && !IMemReady) || ((state == MEM) && !DMemReady);

  // Next state and Mealy outputs; Reset forces every strobe low immediately.
  always_comb begin
    next_state = state;
    IMemReq    = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    DMemRead   = 1'b0;
    DMemWrite  = 1'b0;
    RegWrite   = 1'b0;
    MemtoReg   = 1'b0;
    ALUASrc    = 1'b0;
    ExtendSign = 1'b0;
    PCSrc      = 2'd0;
    RegDst     = 2'd0;
    RegDataSel = 2'd0;
    ALUControl = 4'd0;
    ALUBSrc    = 3'd0;
    Illegal    = 1'b0;
    if (!Reset) begin
      case (state)
        FETCH: begin
          IMemReq = 1'b1;
          if (IMemReady) begin
            IRWrite    = 1'b1;
            PCWrite    = 1'b1;
            next_state = DECODE;
          end else if (cnt_hit) begin
            next_state = TRAP;
          end
        end
        DECODE: begin
          if (Instr == 32'd0) begin
            next_state = FETCH;
          end else if (!legal) begin
            Illegal    = 1'b1;
            next_state = FETCH;
          end else begin
            next_state = EXEC;
          end
        end
        EXEC: begin
          ALUControl = alu_ctl;
          ALUBSrc    = alu_b;
          ALUASrc    = alu_a;
          ExtendSign = ext_sign;
          next_state = FETCH;
          case (cls)
            C_ALU:      next_state = WB;
            C_LW, C_SW: next_state = MEM;
            C_BEQ: if (Zero) begin
              PCWrite = 1'b1;
              PCSrc   = 2'd1;
            end
            C_BNE: if (!Zero) begin
              PCWrite = 1'b1;
              PCSrc   = 2'd1;
            end
            C_J: begin
              PCWrite = 1'b1;
              PCSrc   = 2'd2;
            end
            C_JR: begin
              PCWrite = 1'b1;
              PCSrc   = 2'd3;
            end
            C_JAL: begin
              PCWrite    = 1'b1;
              PCSrc      = 2'd2;
              RegWrite   = 1'b1;
              RegDst     = 2'd2;
              RegDataSel = 2'd1;
            end
            default: next_state = FETCH;
          endcase
        end
        MEM: begin
          DMemRead  = (cls == C_LW);
          DMemWrite = (cls == C_SW);
          // Ready wins over a simultaneous timeout.
          if (DMemReady) begin
            next_state = (cls == C_LW) ? WB : FETCH;
          end else if (cnt_hit) begin
            next_state = TRAP;
          end
        end
        WB: begin
          RegWrite   = 1'b1;
          RegDst     = r_type ? 2'd1 : 2'd0;
          MemtoReg   = (cls == C_LW);
          next_state = FETCH;
        end
        TRAP:    next_state = TRAP;
        default: next_state = FETCH;
      endcase
    end
  end

  // State register, wait counter (cleared on every state change) and sticky fault.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= FETCH;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != state) begin
        wait_cnt <= '0;
      end else if (waiting) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (next_state == TRAP) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign State = state;
  assign Fault = fault_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected output vectors are
// queued by the stimulus and checked by a negedge monitor.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       imemreq;
    logic       irwrite;
    logic       pcwrite;
    logic       dmemread;
    logic       dmemwrite;
    logic       regwrite;
    logic       memtoreg;
    logic       aluasrc;
    logic       extsign;
    logic [1:0] pcsrc;
    logic [1:0] regdst;
    logic [1:0] regdatasel;
    logic [3:0] aluctl;
    logic [2:0] alubsrc;
    logic       illegal;
    logic       fault;
  } exp_t;

  typedef struct {
    exp_t  e;
    string nm;
  } item_t;

  logic        Clk, Reset, Zero, IMemReady, DMemReady;
  logic [31:0] Instr;
  logic        IMemReq, IRWrite, PCWrite, DMemRead, DMemWrite, RegWrite, MemtoReg;
  logic        ALUASrc, ExtendSign, Illegal, Fault;
  logic [1:0]  PCSrc, RegDst, RegDataSel;
  logic [3:0]  ALUControl;
  logic [2:0]  ALUBSrc, State;

  item_t q[$];
  int    errors = 0;
  int    checks = 0;
  exp_t  act;

  multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .Zero(Zero),
    .IMemReady(IMemReady), .DMemReady(DMemReady),
    .IMemReq(IMemReq), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .DMemRead(DMemRead), .DMemWrite(DMemWrite), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .ALUASrc(ALUASrc), .ExtendSign(ExtendSign),
    .PCSrc(PCSrc), .RegDst(RegDst), .RegDataSel(RegDataSel),
    .ALUControl(ALUControl), .ALUBSrc(ALUBSrc), .State(State),
    .Illegal(Illegal), .Fault(Fault)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always_comb begin
    act            = '0;
    act.st         = State;
    act.imemreq    = IMemReq;
    act.irwrite    = IRWrite;
    act.pcwrite    = PCWrite;
    act.dmemread   = DMemRead;
    act.dmemwrite  = DMemWrite;
    act.regwrite   = RegWrite;
    act.memtoreg   = MemtoReg;
    act.aluasrc    = ALUASrc;
    act.extsign    = ExtendSign;
    act.pcsrc      = PCSrc;
    act.regdst     = RegDst;
    act.regdatasel = RegDataSel;
    act.aluctl     = ALUControl;
    act.alubsrc    = ALUBSrc;
    act.illegal    = Illegal;
    act.fault      = Fault;
  end

  // Monitor: one expected vector per cycle, compared mid-cycle.
  always @(negedge Clk) begin
    if (q.size() > 0) begin
      item_t it;
      it = q.pop_front();
      checks++;
      if (act !== it.e) begin
        errors++;
        $display("FAIL %s: got %h want %h (t=%0t)", it.nm, act, it.e, $time);
      end
    end
  end

  function automatic exp_t ex(input logic [2:0] st);
    exp_t r;
    r         = '0;
    r.st      = st;
    r.imemreq = (st == 3'd0);
    return r;
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] funct);
    return {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op);
    return {op, 5'd1, 5'd2, 16'h8004};
  endfunction

  task automatic step(input logic rst, input logic imr, input logic dmr,
                      input logic z, input exp_t e, input string nm);
    item_t it;
    Reset     = rst;
    IMemReady = imr;
    DMemReady = dmr;
    Zero      = z;
    it.e      = e;
    it.nm     = nm;
    q.push_back(it);
    @(posedge Clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] ins, input string nm);
    exp_t e;
    Instr     = ins;
    e         = ex(3'd0);
    e.irwrite = 1'b1;
    e.pcwrite = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0, e, nm);
  endtask

  task automatic decode(input string nm);
    step(1'b0, 1'b0, 1'b0, 1'b0, ex(3'd1), nm);
  endtask

  task automatic exec_alu(input logic [3:0] ctl, input logic [2:0] b,
                          input logic a, input logic sx, input string nm);
    exp_t e;
    e         = ex(3'd2);
    e.aluctl  = ctl;
    e.alubsrc = b;
    e.aluasrc = a;
    e.extsign = sx;
    step(1'b0, 1'b0, 1'b0, 1'b0, e, nm);
  endtask

  task automatic wb(input logic [1:0] rd, input logic m2r, input string nm);
    exp_t e;
    e          = ex(3'd4);
    e.regwrite = 1'b1;
    e.regdst   = rd;
    e.memtoreg = m2r;
    step(1'b0, 1'b0, 1'b0, 1'b0, e, nm);
  endtask

  initial begin
    exp_t e;
    Reset = 1'b1; IMemReady = 1'b0; DMemReady = 1'b0; Zero = 1'b0;
    Instr = 32'd0;
    @(posedge Clk);
    #1;

    e = ex(3'd0); e.imemreq = 1'b0;
    step(1'b1, 1'b1, 1'b1, 1'b0, e, "reset_held");

    // ADD: 4 cycles
    fetch(rtype(6'd32), "add_fetch");
    decode("add_decode");
    exec_alu(4'd2, 3'd0, 1'b0, 1'b0, "add_exec");
    wb(2'd1, 1'b0, "add_wb");

    // LW with DMemReady after 3 wait cycles: 8 cycles
    fetch(itype(6'd35), "lw_fetch");
    decode("lw_decode");
    exec_alu(4'd2, 3'd1, 1'b0, 1'b1, "lw_exec");
    e = ex(3'd3); e.dmemread = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, e, "lw_mem_wait");
    step(1'b0, 1'b0, 1'b1, 1'b0, e, "lw_mem_ready");
    wb(2'd0, 1'b1, "lw_wb");

    // BEQ taken
    fetch(itype(6'd4), "beq_fetch");
    decode("beq_decode");
    e = ex(3'd2); e.aluctl = 4'd6; e.extsign = 1'b1; e.pcwrite = 1'b1; e.pcsrc = 2'd1;
    step(1'b0, 1'b0, 1'b0, 1'b1, e, "beq_exec_taken");

    // BNE with Zero=1: no branch
    fetch(itype(6'd5), "bne_fetch");
    decode("bne_decode");
    e = ex(3'd2); e.aluctl = 4'd6; e.extsign = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1, e, "bne_exec_not_taken");

    // JAL
    fetch({6'd3, 26'h0000100}, "jal_fetch");
    decode("jal_decode");
    e = ex(3'd2); e.pcwrite = 1'b1; e.pcsrc = 2'd2; e.regwrite = 1'b1;
    e.regdst = 2'd2; e.regdatasel = 2'd1;
    step(1'b0, 1'b0, 1'b0, 1'b0, e, "jal_exec");

    // SW zero-wait: 4 cycles; stray DMemReady during decode is ignored
    fetch(itype(6'd43), "sw_fetch");
    step(1'b0, 1'b1, 1'b1, 1'b0, ex(3'd1), "sw_decode_stray_ready");
    exec_alu(4'd2, 3'd1, 1'b0, 1'b1, "sw_exec");
    e = ex(3'd3); e.dmemwrite = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0, e, "sw_mem");

    // SLL (non-NOP)
    fetch({6'd0, 5'd0, 5'd2, 5'd3, 5'd4, 6'd0}, "sll_fetch");
    decode("sll_decode");
    exec_alu(4'd10, 3'd4, 1'b1, 1'b0, "sll_exec");
    wb(2'd1, 1'b0, "sll_wb");

    // ORI: zero-extended immediate, rt destination
    fetch(itype(6'd13), "ori_fetch");
    decode("ori_decode");
    exec_alu(4'd1, 3'd1, 1'b0, 1'b0, "ori_exec");
    wb(2'd0, 1'b0, "ori_wb");

    // JR
    fetch(rtype(6'd8), "jr_fetch");
    decode("jr_decode");
    e = ex(3'd2); e.pcwrite = 1'b1; e.pcsrc = 2'd3;
    step(1'b0, 1'b0, 1'b0, 1'b0, e, "jr_exec");

    // NOP: 2 cycles
    fetch(32'd0, "nop_fetch");
    decode("nop_decode");

    // Illegal opcode 63
    fetch({6'd63, 26'd5}, "ill_fetch");
    e = ex(3'd1); e.illegal = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, e, "ill_decode");

    // IMemReady on the 15th wait cycle beats the timeout
    Instr = 32'd0;
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 1'b0, 1'b0, ex(3'd0), "fetch_wait");
    fetch(32'd0, "fetch_ready_at_limit");
    decode("nop2_decode");

    // Reset mid-MEM suppresses DMemWrite
    fetch(itype(6'd43), "sw2_fetch");
    decode("sw2_decode");
    exec_alu(4'd2, 3'd1, 1'b0, 1'b1, "sw2_exec");
    e = ex(3'd3); e.dmemwrite = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, e, "sw2_mem_wait");
    e = ex(3'd0); e.imemreq = 1'b0;
    step(1'b1, 1'b0, 1'b1, 1'b0, e, "sw2_mem_reset");

    // IMemReady held low: TRAP after 15 wait cycles, sticky until Reset
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0, 1'b0, ex(3'd0), "timeout_wait");
    e = ex(3'd5); e.fault = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, e, "trap");
    step(1'b0, 1'b1, 1'b1, 1'b1, e, "trap_hold");
    e = ex(3'd0); e.imemreq = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, e, "trap_reset");

    // Recovery after reset
    fetch(itype(6'd8), "addi_fetch");
    decode("addi_decode");
    exec_alu(4'd2, 3'd1, 1'b0, 1'b1, "addi_exec");
    wb(2'd0, 1'b0, "addi_wb");
    step(1'b0, 1'b0, 1'b0, 1'b0, ex(3'd0), "final_fetch");

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
